usb_tx_line_encoder: RTL and testbench

- Transmit-side line stage that sits directly downstream of the packet-to-serial converter.
- Consumes the serial bit stream (outBit qualified by put_outbound), buffers it, inserts USB bit-stuffing, NRZI-encodes it, and drives the differential pair (dp/dm).
- Appends the end-of-packet sequence (SE0, SE0, J) after each packet.
- A small FIFO absorbs the rate mismatch caused by stuffed bits, because the upstream converter cannot be stalled.

---
 rtl/usb_tx_line_encoder.sv | 209 ++++++++++++++++++++
 tb/tb_usb_tx_line_encoder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_line_encoder.sv
// usb_tx_line_encoder
//   Transmit line stage placed after the packet-to-serial converter. Serial
//   bits are buffered in a small FIFO and then bit-stuffed and NRZI-encoded
//   onto the D+/D- pair. Every packet is followed by the end-of-packet
//   sequence SE0, SE0, J. The FIFO absorbs the extra line time taken by
//   stuffed bits, because the upstream converter cannot be stalled.
//
// Ports
//   clk       : system clock, all state on posedge
//   rst_n     : asynchronous active-low reset
//   in_bit    : serial data bit from upstream
//   in_valid  : in_bit qualifier, contiguous for the length of a packet
//   dp, dm    : registered D+ / D- line levels (J = dp 1, dm 0)
//   busy      : FIFO non-empty or line FSM not idle
//   overflow  : sticky, a push was attempted while the FIFO was full
module usb_tx_line_encoder #(
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned STUFF_RUN = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_bit,
  input  logic in_valid,
  output logic dp,
  output logic dm,
  output logic busy,
  output logic overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(STUFF_RUN + 1);
  localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);
  localparam logic [CW-1:0] ONES_ONE  = CW'(1);
  localparam logic [CW-1:0] STUFF_LIM = CW'(STUFF_RUN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_STUFF,
    S_EOP1,
    S_EOP2,
    S_EOPJ
  } state_e;

  // FIFO storage: each entry is {eop, data}
  logic [1:0]    mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          in_valid_q;
  logic          overflow_q, overflow_d;

  // line FSM state
  state_e        state_q, state_d;
  logic [CW-1:0] ones_q, ones_d;
  logic          level_q, level_d;
  logic          dp_q, dp_d;
  logic          dm_q, dm_d;

  logic          fifo_empty;
  logic          fifo_full;
  logic [1:0]    head;
  logic          push_req;
  logic          push_we;
  logic [1:0]    push_ent;
  logic          pop;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head       = mem_q[rd_ptr_q[AW-1:0]];

  // A data entry on every valid bit; the EOP token on the falling edge of
  // in_valid (seen through the registered copy).
  assign push_req = in_valid | in_valid_q;
  assign push_ent = in_valid ? {1'b0, in_bit} : 2'b10;
  // A pop in the same edge frees a slot, so a full FIFO still accepts.
  assign push_we  = push_req & (~fifo_full | pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    overflow_d = overflow_q;
    if (push_req) begin
      if (push_we) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        overflow_d = 1'b1;
      end
    end
    rd_ptr_d = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (push_we) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_ent;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      in_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      in_valid_q <= in_valid;
      overflow_q <= overflow_d;
    end
  end

  // Line FSM. dp/dm are registered with the value belonging to the state
  // being entered, so the line shows each state's symbol while in it.
  // IDLE always holds level=J and ones=0, so a data pop in IDLE uses the
  // same encode path as SEND. The stuff decision is made when the sixth 1
  // is popped (enter STUFF), which puts a stuffed 0 ahead of any EOP token.
  always_comb begin
    state_d = state_q;
    ones_d  = ones_q;
    level_d = level_q;
    dp_d    = dp_q;
    dm_d    = dm_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE, S_SEND: begin
        if (state_q == S_IDLE) begin
          dp_d = 1'b1;
          dm_d = 1'b0;
        end
        if (!fifo_empty) begin
          pop = 1'b1;
          if (!head[1]) begin
            if (head[0]) begin
              ones_d = ones_q + ONES_ONE;
            end else begin
              ones_d  = '0;
              level_d = ~level_q;
            end
            dp_d = level_d;
            dm_d = ~level_d;
            if (head[0] && (ones_q + ONES_ONE == STUFF_LIM)) begin
              state_d = S_STUFF;
            end else begin
              state_d = S_SEND;
            end
          end else if (state_q == S_SEND) begin
            // EOP token ends the packet; an orphan token in IDLE is dropped
            state_d = S_EOP1;
            dp_d    = 1'b0;
            dm_d    = 1'b0;
          end
        end
      end
      S_STUFF: begin
        ones_d  = '0;
        level_d = ~level_q;
        dp_d    = level_d;
        dm_d    = ~level_d;
        state_d = S_SEND;
      end
      S_EOP1: begin
        dp_d    = 1'b0;
        dm_d    = 1'b0;
        state_d = S_EOP2;
      end
      S_EOP2: begin
        dp_d    = 1'b1;
        dm_d    = 1'b0;
        level_d = 1'b1;
        ones_d  = '0;
        state_d = S_EOPJ;
      end
      S_EOPJ: begin
        dp_d    = 1'b1;
        dm_d    = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        dp_d    = 1'b1;
        dm_d    = 1'b0;
        level_d = 1'b1;
        ones_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ones_q  <= '0;
      level_q <= 1'b1;
      dp_q    <= 1'b1;
      dm_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ones_q  <= ones_d;
      level_q <= level_d;
      dp_q    <= dp_d;
      dm_q    <= dm_d;
    end
  end

  assign dp       = dp_q;
  assign dm       = dm_q;
  assign busy     = ~fifo_empty | (state_q != S_IDLE);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_usb_tx_line_encoder.sv
// Testbench for usb_tx_line_encoder: two instances (DEPTH 32 and DEPTH 8)
// share the inputs. Line symbols are sampled each negedge and compared with
// a queue of expected symbols built from the stuffing/NRZI/EOP rules.
module tb_usb_tx_line_encoder;

  localparam logic [1:0] LJ   = 2'b10;
  localparam logic [1:0] LK   = 2'b01;
  localparam logic [1:0] LSE0 = 2'b00;

  logic clk = 1'b0;
  logic rst_n;
  logic in_bit;
  logic in_valid;
  logic dp_a, dm_a, busy_a, ovf_a;
  logic dp_b, dm_b, busy_b, ovf_b;

  int errors = 0;
  int checks = 0;

  bit         pkt[$];
  bit         sched_v[$];
  bit         sched_b[$];
  logic [1:0] cap_line[$];
  logic       cap_busy[$];
  logic [1:0] exp_line[$];
  logic       exp_busy[$];

  always #5 clk = ~clk;

  usb_tx_line_encoder #(.DEPTH(32), .STUFF_RUN(6)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid),
    .dp(dp_a), .dm(dm_a), .busy(busy_a), .overflow(ovf_a)
  );

  usb_tx_line_encoder #(.DEPTH(8), .STUFF_RUN(6)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid),
    .dp(dp_b), .dm(dm_b), .busy(busy_b), .overflow(ovf_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // sample the line, then drive inputs for the next posedge
  task automatic step(input bit v, input bit b);
    @(negedge clk);
    cap_line.push_back({dp_a, dm_a});
    cap_busy.push_back(busy_a);
    in_valid = v;
    in_bit   = b;
  endtask

  task automatic exp_sym(input logic [1:0] s, input logic bz);
    exp_line.push_back(s);
    exp_busy.push_back(bz);
  endtask

  // Reference: each packet starts at J; a 0 toggles, a 1 holds; after six
  // consecutive 1s an extra toggle is inserted; then SE0, SE0, J.
  task automatic model_packet();
    logic lvl;
    int   run;
    lvl = 1'b1;
    run = 0;
    foreach (pkt[i]) begin
      if (pkt[i]) begin
        run++;
      end else begin
        lvl = ~lvl;
        run = 0;
      end
      exp_sym(lvl ? LJ : LK, 1'b1);
      if (run == 6) begin
        lvl = ~lvl;
        run = 0;
        exp_sym(lvl ? LJ : LK, 1'b1);
      end
    end
    exp_sym(LSE0, 1'b1);
    exp_sym(LSE0, 1'b1);
    exp_sym(LJ, 1'b1);
  endtask

  task automatic sched_packet();
    foreach (pkt[i]) begin
      sched_v.push_back(1'b1);
      sched_b.push_back(pkt[i]);
    end
  endtask

  // sample 0 precedes the first push; sample 1 follows it (line still J)
  task automatic begin_test();
    sched_v.delete();
    sched_b.delete();
    cap_line.delete();
    cap_busy.delete();
    exp_line.delete();
    exp_busy.delete();
    exp_sym(LJ, 1'b0);
    exp_sym(LJ, 1'b1);
  endtask

  task automatic run_test(input string tag, input int tail);
    foreach (sched_v[i]) step(sched_v[i], sched_b[i]);
    repeat (tail) step(1'b0, 1'b0);
    check({tag, "_len"}, 32'(cap_line.size() >= exp_line.size()), 32'd1);
    while (exp_line.size() < cap_line.size()) exp_sym(LJ, 1'b0);
    for (int i = 0; i < cap_line.size(); i++) begin
      check($sformatf("%s_line[%0d]", tag, i), 32'(cap_line[i]), 32'(exp_line[i]));
      check($sformatf("%s_busy[%0d]", tag, i), 32'(cap_busy[i]), 32'(exp_busy[i]));
    end
    check({tag, "_ovf32"}, 32'(ovf_a), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    repeat (4) begin
      in_valid = 1'($urandom);
      in_bit   = 1'($urandom);
      @(negedge clk);
      check({tag, "_rst_line"}, 32'({dp_a, dm_a}), 32'(LJ));
      check({tag, "_rst_busy"}, 32'(busy_a), 32'd0);
      check({tag, "_rst_ovf"}, 32'(ovf_a), 32'd0);
      check({tag, "_rst_ovf8"}, 32'(ovf_b), 32'd0);
      check({tag, "_rst_busy8"}, 32'(busy_b), 32'd0);
    end
    in_valid = 1'b0;
    in_bit   = 1'b0;
    rst_n    = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check({tag, "_post_line"}, 32'({dp_a, dm_a}), 32'(LJ));
      check({tag, "_post_busy"}, 32'(busy_a), 32'd0);
    end
  endtask

  initial begin
    int tog;
    int len;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    do_reset("init");

    // sync pattern: no stuffing
    begin_test();
    pkt = '{0, 0, 0, 0, 0, 0, 0, 1};
    sched_packet();
    model_packet();
    run_test("sync", 12);
    check("sync_ovf8", 32'(ovf_b), 32'd0);

    // seven 1s then 0: one stuffed bit mid-packet
    begin_test();
    pkt = '{1, 1, 1, 1, 1, 1, 1, 0};
    sched_packet();
    model_packet();
    run_test("stuff", 12);
    check("stuff_ovf8", 32'(ovf_b), 32'd0);

    // exactly six 1s: stuffed 0 precedes EOP
    begin_test();
    pkt = '{1, 1, 1, 1, 1, 1};
    sched_packet();
    model_packet();
    run_test("six1", 12);

    // 99 ones: 16 stuffs; DEPTH 8 overflows, DEPTH 32 does not
    begin_test();
    pkt.delete();
    repeat (99) pkt.push_back(1'b1);
    sched_packet();
    model_packet();
    run_test("ones99", 30);
    check("ones99_ovf8", 32'(ovf_b), 32'd1);
    tog = 0;
    for (int i = 2; i < cap_line.size() && cap_line[i] != LSE0; i++) begin
      if (cap_line[i] != cap_line[i-1]) tog++;
    end
    check("ones99_stuffs", 32'(tog), 32'd16);
    do_reset("after99");

    // back-to-back packets with a one-cycle gap: one idle J between them
    begin_test();
    pkt = '{0, 0, 0, 0, 0, 0, 0, 1};
    sched_packet();
    model_packet();
    sched_v.push_back(1'b0);
    sched_b.push_back(1'b0);
    exp_sym(LJ, 1'b1);
    pkt.delete();
    for (int i = 0; i < 12; i++) pkt.push_back(1'($urandom));
    sched_packet();
    model_packet();
    run_test("b2b", 16);

    // random packets, biased toward 1s to exercise stuffing
    for (int r = 0; r < 8; r++) begin
      begin_test();
      pkt.delete();
      len = $urandom_range(1, 30);
      for (int i = 0; i < len; i++) pkt.push_back($urandom_range(0, 3) != 0);
      sched_packet();
      model_packet();
      run_test($sformatf("rnd%0d", r), 14);
      check($sformatf("rnd%0d_ovf8", r), 32'(ovf_b), 32'd0);
    end

    // reset in the middle of a packet of zeros (line at K when it hits)
    begin_test();
    repeat (11) step(1'b1, 1'b0);
    check("mid_pre_line", 32'({dp_a, dm_a}), 32'(LK));
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("mid_async_line", 32'({dp_a, dm_a}), 32'(LJ));
    check("mid_async_busy", 32'(busy_a), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      check("mid_after_line", 32'({dp_a, dm_a}), 32'(LJ));
      check("mid_after_busy", 32'(busy_a), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
